// File: rtl/ac_sched_if.sv
// ============================================================================
// Module      : ac_sched_if
// Description : Sample input and actuator output bundle for the AC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ac_sched_if #(
   parameter int TW = 5
);
   logic          enable;
   logic          temp_valid;
   logic [TW-1:0] temperature;
   logic          heating;
   logic          cooling;
   logic          lockout;
   logic [1:0]    state;

   modport master (
      output enable, temp_valid, temperature,
      input  heating, cooling, lockout, state
   );

   modport slave (
      input  enable, temp_valid, temperature,
      output heating, cooling, lockout, state
   );
endinterface

`default_nettype wire

// File: rtl/ac_sched.sv
// ============================================================================
// Module      : ac_sched
// Description : Hysteresis heat/cool sequencer with minimum on-time and lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ac_sched #(
   parameter int TW       = 5,
   parameter int HEAT_ON  = 18,
   parameter int HEAT_OFF = 20,
   parameter int COOL_ON  = 22,
   parameter int COOL_OFF = 20,
   parameter int MIN_ON   = 4,
   parameter int MIN_OFF  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   ac_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HEAT = 2'b01,
      ST_COOL = 2'b10,
      ST_LOCK = 2'b11
   } state_t;

   localparam logic [TW-1:0] C_HEAT_ON  = TW'(HEAT_ON);
   localparam logic [TW-1:0] C_HEAT_OFF = TW'(HEAT_OFF);
   localparam logic [TW-1:0] C_COOL_ON  = TW'(COOL_ON);
   localparam logic [TW-1:0] C_COOL_OFF = TW'(COOL_OFF);
   localparam logic [7:0]    C_ON_LOAD  = 8'(MIN_ON - 1);
   localparam logic [7:0]    C_OFF_LOAD = 8'(MIN_OFF - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       heating_q, cooling_q, lockout_q;

   logic w_cnt_zero;
   logic w_start;
   assign w_cnt_zero = (cnt_q == 8'd0);
   assign w_start    = bus.enable & bus.temp_valid;

   // One shared counter times both the run minimum and the lockout interval.
   always_comb begin
      state_d = state_q;
      cnt_d   = w_cnt_zero ? cnt_q : cnt_q - 8'd1;
      case (state_q)
         ST_IDLE: begin
            if (w_start && (bus.temperature <= C_HEAT_ON)) begin
               state_d = ST_HEAT;
               cnt_d   = C_ON_LOAD;
            end else if (w_start && (bus.temperature >= C_COOL_ON)) begin
               state_d = ST_COOL;
               cnt_d   = C_ON_LOAD;
            end
         end
         ST_HEAT: begin
            if (w_cnt_zero && ((bus.temp_valid && (bus.temperature >= C_HEAT_OFF)) ||
                               !bus.enable)) begin
               state_d = ST_LOCK;
               cnt_d   = C_OFF_LOAD;
            end
         end
         ST_COOL: begin
            if (w_cnt_zero && ((bus.temp_valid && (bus.temperature <= C_COOL_OFF)) ||
                               !bus.enable)) begin
               state_d = ST_LOCK;
               cnt_d   = C_OFF_LOAD;
            end
         end
         ST_LOCK: begin
            if (w_cnt_zero) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         heating_q <= 1'b0;
         cooling_q <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         heating_q <= (state_d == ST_HEAT);
         cooling_q <= (state_d == ST_COOL);
         lockout_q <= (state_d == ST_LOCK);
      end
   end

   assign bus.heating = heating_q;
   assign bus.cooling = cooling_q;
   assign bus.lockout = lockout_q;
   assign bus.state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ac_sched.sv
// ============================================================================
// Module      : tb_ac_sched
// Description : Vector-table and scoreboard bench for the AC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ac_sched;

   typedef struct {
      logic       en;
      logic       v;
      logic [4:0] t;
      logic [1:0] st;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   vec_t       vecs[$];
   logic [4:0] sb[$];

   ac_sched_if #(.TW(5)) bus ();

   ac_sched #(
      .TW(5), .HEAT_ON(18), .HEAT_OFF(20), .COOL_ON(22), .COOL_OFF(20),
      .MIN_ON(4), .MIN_OFF(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, heating, cooling, lockout} implied by a state code
   function automatic logic [4:0] exp_of(input logic [1:0] st);
      return {st, st == 2'b01, st == 2'b10, st == 2'b11};
   endfunction

   function automatic logic [4:0] act();
      return {bus.state, bus.heating, bus.cooling, bus.lockout};
   endfunction

   task automatic check(input string name, input logic [4:0] a, input logic [4:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got st/h/c/l=%b required %b at %0t", name, a, e, $time);
      end
   endtask

   task automatic check_excl(input string name);
      checks++;
      if (bus.heating && bus.cooling) begin
         errors++;
         $display("FAIL %s: heating=1 cooling=1 required not both at %0t", name, $time);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, compare after the edge.
   task automatic step(input logic en, input logic v, input logic [4:0] t,
                       input logic [1:0] st, input string name);
      logic [4:0] e;
      bus.enable      = en;
      bus.temp_valid  = v;
      bus.temperature = t;
      sb.push_back(exp_of(st));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(name, act(), e);
      check_excl(name);
   endtask

   function automatic void add(input logic en, input logic v, input logic [4:0] t,
                               input logic [1:0] st);
      vec_t r;
      r.en = en; r.v = v; r.t = t; r.st = st;
      vecs.push_back(r);
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.enable      = 1'b0;
      bus.temp_valid  = 1'b0;
      bus.temperature = 5'd0;

      // heat run: stop seen during min-on is dropped, then 19 does not stop
      add(1,1,15,2'b01); add(1,1,21,2'b01); add(1,0,0,2'b01);  add(1,0,0,2'b01);
      add(1,0,0,2'b01);  add(1,1,19,2'b01); add(1,1,20,2'b11);
      add(1,1,0,2'b11);  add(1,1,0,2'b11);  add(1,1,0,2'b11);  add(1,1,0,2'b00);
      // sample 0 restarts heat at the earliest slot; enable drop exits after min-on
      add(1,1,0,2'b01);  add(1,0,0,2'b01);  add(1,0,0,2'b01);  add(1,0,0,2'b01);
      add(0,0,0,2'b11);  add(0,0,0,2'b11);  add(0,0,0,2'b11);  add(0,0,0,2'b11);
      add(0,0,0,2'b00);
      // IDLE threshold boundaries and enable gating
      add(1,1,19,2'b00); add(1,1,21,2'b00); add(0,1,10,2'b00); add(1,0,0,2'b00);
      add(1,1,18,2'b01);
      // rapid reversal via continuous 31
      add(1,1,18,2'b01); add(1,1,18,2'b01); add(1,1,18,2'b01); add(1,1,31,2'b11);
      add(1,1,31,2'b11); add(1,1,31,2'b11); add(1,1,31,2'b11); add(1,1,31,2'b00);
      add(1,1,31,2'b10);
      // cool run: 21 at cnt==0 keeps cooling, 20 stops
      add(1,1,20,2'b10); add(1,1,31,2'b10); add(1,0,0,2'b10);  add(1,1,21,2'b10);
      add(1,1,20,2'b11); add(1,1,22,2'b11); add(1,1,22,2'b11); add(1,1,22,2'b11);
      add(1,1,22,2'b00);
      // cool start at 22, enable dropped: exits at entry+4
      add(1,1,22,2'b10); add(0,0,0,2'b10);  add(0,0,0,2'b10);  add(0,0,0,2'b10);
      add(0,0,0,2'b11);  add(0,1,31,2'b11); add(0,1,31,2'b11); add(0,1,31,2'b11);
      add(0,1,31,2'b00); add(0,1,31,2'b00);

      #3;
      check("reset_state", act(), 5'b00000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].v, vecs[i].t, vecs[i].st, $sformatf("vec%0d", i));
      end

      // asynchronous reset in the middle of a heat run
      step(1, 1, 15, 2'b01, "mid_heat");
      bus.temp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", act(), 5'b00000);
      #2;
      rst_n = 1'b1;
      step(1, 0, 0, 2'b00, "post_reset_idle0");
      step(1, 0, 0, 2'b00, "post_reset_idle1");
      step(1, 1, 15, 2'b01, "post_reset_restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
